count_ctrl: RTL and testbench
=============================

# count_ctrl

Run controller for the lab's BCD counter datapath. Debounces the raw start/pause and clear keys (plus an optional direction key) and arbitrates same-cycle presses. Runs a four-state FSM and drives the external counter with registered one-cycle step and clear strobes, paced by an internal prescaler. It sits between the board keys and the counter/display path, and replaces the single-key pause toggle.

## Interface
- TICK_DIV, default 50_000_000: clk cycles per count step; legal range ≥ 2.
- DEB_CYCLES, default 3: consecutive stable synchronized samples required to accept a key level change; legal range ≥ 1.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_start_n  in  1  raw start/pause key; active-low; asynchronous to clk.
- key_clr_n  in  1  raw clear key; active-low; asynchronous.
- key_dir_n  in  1  raw direction key; active-low; used only with CNT_CTRL_DOWN_EN.
- cnt_max  in  1  from counter: count equals its upper terminal value.
- cnt_zero  in  1  from counter: count equals zero.
- cnt_step  out  1  one-cycle pulse: counter advances one step in direction cnt_up.
- cnt_clr  out  1  one-cycle pulse: counter clears to zero.
- cnt_up  out  1  count direction: 1 = up, 0 = down.
- run  out  1  high while state is RUN.
- state  out  2  FSM state code.
- done  out  1  one-cycle pulse when the terminal value is reached.

## Operation
- Reset values: state IDLE, cnt_step 0, cnt_clr 0, done 0, run 0, cnt_up 1, prescaler 0, all key filters at released level 1.
- All outputs are registered.
- Key filter, applied to each key:
  - two-flop synchronizer, then stability counter `cnt`;
  - if the synchronized sample equals the stable level `lvl`: cnt <= 0;
  - else if cnt == DEB_CYCLES-1: lvl <= sample, cnt <= 0;
  - else cnt++.
  - `press` is high for exactly one cycle after lvl falls 1->0. Release generates nothing.
- Arbitration when several presses occur in one cycle: priority clear > start > dir. Exactly one press is accepted; lower-priority presses are dropped, not queued.
- FSM states: IDLE=0, RUN=1, PAUSE=2, HOLD=3.
  - clear, any state -> IDLE; cnt_clr pulse; prescaler <= 0.
  - start: IDLE->RUN (prescaler <= 0); RUN->PAUSE; PAUSE->RUN (prescaler resumes); HOLD->RUN with cnt_clr pulse and prescaler <= 0.
- Prescaler:
  - counts 0..TICK_DIV-1 only in RUN and holds its value otherwise;
  - on the RUN cycle where prescaler == TICK_DIV-1 it wraps to 0, and:
    - terminal input (cnt_max when cnt_up=1, cnt_zero when cnt_up=0) low -> cnt_step pulse;
    - terminal input high -> no step; state -> HOLD; done pulse.
- If a start press and a prescaler rollover occur in the same cycle, the press wins: RUN->PAUSE, no step, and the prescaler holds at TICK_DIV-1.
- Terminal inputs are sampled only at rollover.

## Timing
- Raw key held low and stable before clk edge 1: lvl falls at edge DEB_CYCLES+2; the state and strobes update at edge DEB_CYCLES+3.
- Any bounce shorter than DEB_CYCLES synchronized cycles is ignored.
- In RUN, cnt_step period is exactly TICK_DIV cycles. The first step comes TICK_DIV cycles after entry to RUN from IDLE or HOLD.
- cnt_clr and done are each high for exactly one cycle.
- Asserting rst_n low mid-operation immediately forces all reset values. No cnt_step or cnt_clr is emitted on release from reset.

## Configuration
- Macro: CNT_CTRL_DOWN_EN.
- Defined:
  - a dir filter is instantiated for key_dir_n;
  - an accepted dir press toggles cnt_up in IDLE, PAUSE or HOLD;
  - a dir press is ignored in RUN.
- Undefined:
  - key_dir_n is unused and no filter is instantiated for it;
  - cnt_up is constant 1 and cnt_zero is ignored.

## Structure
- Package count_ctrl_pkg holds:
  - the state codes IDLE/RUN/PAUSE/HOLD;
  - default values for TICK_DIV and DEB_CYCLES.
- Sub-module key_filter holds the synchronizer, stability counter and press pulse. It takes DEB_CYCLES as a parameter and is instantiated once per key.
- The FSM, arbiter and prescaler live in count_ctrl.

## Test plan
Bench parameters: TICK_DIV=4, DEB_CYCLES=3.
- Reset, then press start (held low 10 cycles): run=1 at edge 6; cnt_step pulses at cycles 10, 14, 18, …
- In RUN, a start press gives PAUSE with no steps; a second press gives RUN with the prescaler resuming, so the next step comes TICK_DIV minus the elapsed count cycles later.
- Glitch low for 2 cycles on key_start_n: no state change. A 3-cycle low gives a state change.
- Start and clear become stable on the same cycle: state IDLE, one cnt_clr pulse, start dropped.
- cnt_max=1 in RUN: at the next rollover, no cnt_step, done pulses once, state=HOLD. Then a start press gives a cnt_clr pulse and RUN.
- With CNT_CTRL_DOWN_EN, a dir press in IDLE sets cnt_up=0; a dir press in RUN is ignored. With cnt_zero=1 at rollover the FSM enters HOLD. Also check that asserting rst_n mid-RUN clears all outputs at once.

Source files
------------

// File: rtl/count_ctrl_pkg.sv
// Shared state codes and parameter defaults for the count_ctrl run controller.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int unsigned TICK_DIV_DEF   = 50_000_000;
  localparam int unsigned DEB_CYCLES_DEF = 3;

endpackage

// File: rtl/key_filter.sv
// Key conditioner: two-flop synchronizer, stability debounce and a one-cycle press strobe.
module key_filter
  import count_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    r_sync;
  logic          r_lvl;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          w_sample;

  assign w_sample = r_sync[1];

  // A level change is accepted only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_lvl   <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_press <= 1'b0;
      if (w_sample == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        r_lvl   <= w_sample;
        r_cnt   <= '0;
        r_press <= ~w_sample;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/count_ctrl.sv
// Run controller for the BCD counter: key arbitration, run/pause/hold FSM and step prescaler.
// Optional down-counting with a direction key is enabled by defining CNT_CTRL_DOWN_EN.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_clr_n,
  input  logic       key_dir_n,
  input  logic       cnt_max,
  input  logic       cnt_zero,
  output logic       cnt_step,
  output logic       cnt_clr,
  output logic       cnt_up,
  output logic       run,
  output logic [1:0] state,
  output logic       done
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_e        r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          r_step, w_step_nxt;
  logic          r_clr, w_clr_nxt;
  logic          r_done, w_done_nxt;
  logic          r_up, w_up_nxt;
  logic          r_run;
  logic          w_start_p, w_clr_p, w_term;

  key_filter #(.DEB_CYCLES(DEB_CYCLES)) u_start_flt (
    .clk(clk), .rst_n(rst_n), .i_key_n(key_start_n), .o_press(w_start_p)
  );

  key_filter #(.DEB_CYCLES(DEB_CYCLES)) u_clr_flt (
    .clk(clk), .rst_n(rst_n), .i_key_n(key_clr_n), .o_press(w_clr_p)
  );

`ifdef CNT_CTRL_DOWN_EN
  logic w_dir_p;

  key_filter #(.DEB_CYCLES(DEB_CYCLES)) u_dir_flt (
    .clk(clk), .rst_n(rst_n), .i_key_n(key_dir_n), .o_press(w_dir_p)
  );

  assign w_term = r_up ? cnt_max : cnt_zero;
`else
  logic w_unused;

  assign w_unused = &{1'b0, key_dir_n, cnt_zero};
  assign w_term   = cnt_max;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_step  <= 1'b0;
      r_clr   <= 1'b0;
      r_done  <= 1'b0;
      r_up    <= 1'b1;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_step  <= w_step_nxt;
      r_clr   <= w_clr_nxt;
      r_done  <= w_done_nxt;
      r_up    <= w_up_nxt;
      r_run   <= (w_state_nxt == RUN);
    end
  end

  // Priority clear > start > dir; a start press on a rollover cycle suppresses the step.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_step_nxt  = 1'b0;
    w_clr_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_up_nxt    = r_up;
    if (w_clr_p) begin
      w_state_nxt = IDLE;
      w_clr_nxt   = 1'b1;
      w_presc_nxt = '0;
    end else if (w_start_p) begin
      case (r_state)
        IDLE: begin
          w_state_nxt = RUN;
          w_presc_nxt = '0;
        end
        RUN:   w_state_nxt = PAUSE;
        PAUSE: w_state_nxt = RUN;
        HOLD: begin
          w_state_nxt = RUN;
          w_clr_nxt   = 1'b1;
          w_presc_nxt = '0;
        end
      endcase
    end else begin
`ifdef CNT_CTRL_DOWN_EN
      if (w_dir_p && (r_state != RUN)) begin
        w_up_nxt = ~r_up;
      end
`endif
      if (r_state == RUN) begin
        if (r_presc == PRE_LAST) begin
          w_presc_nxt = '0;
          if (w_term) begin
            w_state_nxt = HOLD;
            w_done_nxt  = 1'b1;
          end else begin
            w_step_nxt = 1'b1;
          end
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
    end
  end

  assign cnt_step = r_step;
  assign cnt_clr  = r_clr;
  assign cnt_up   = r_up;
  assign run      = r_run;
  assign state    = r_state;
  assign done     = r_done;

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: directed scenarios plus random key/terminal traffic vs a behavioural model.
module tb_count_ctrl;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DEB      = 3;
  localparam int unsigned HL       = DEB + 2;
`ifdef CNT_CTRL_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_start_n = 1'b1;
  logic       key_clr_n = 1'b1;
  logic       key_dir_n = 1'b1;
  logic       cnt_max = 1'b0;
  logic       cnt_zero = 1'b0;
  logic       cnt_step, cnt_clr, cnt_up, run, done;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  // Model: accepted key levels from raw history, FSM mode and elapsed run cycles.
  int m_st, m_ph;
  bit m_up, e_step, e_clr, e_done;
  bit hist[3][HL];
  bit m_lvl[3];
  bit pend[3];

  count_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .key_start_n(key_start_n), .key_clr_n(key_clr_n),
    .key_dir_n(key_dir_n), .cnt_max(cnt_max), .cnt_zero(cnt_zero),
    .cnt_step(cnt_step), .cnt_clr(cnt_clr), .cnt_up(cnt_up), .run(run),
    .state(state), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_ph = 0; m_up = 1'b1;
    e_step = 1'b0; e_clr = 1'b0; e_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_lvl[k] = 1'b1;
      pend[k]  = 1'b0;
      for (int i = 0; i < HL; i++) hist[k][i] = 1'b1;
    end
  endtask

  task automatic model_edge();
    bit raw[3];
    bit term;
    raw[0] = key_clr_n; raw[1] = key_start_n; raw[2] = key_dir_n;
    e_step = 1'b0; e_clr = 1'b0; e_done = 1'b0;
    if (pend[0]) begin
      m_st = 0; e_clr = 1'b1; m_ph = 0;
    end else if (pend[1]) begin
      if (m_st == 0) begin m_st = 1; m_ph = 0; end
      else if (m_st == 1) m_st = 2;
      else if (m_st == 2) m_st = 1;
      else begin m_st = 1; m_ph = 0; e_clr = 1'b1; end
    end else begin
      if (pend[2] && DOWN_EN && m_st != 1) m_up = !m_up;
      if (m_st == 1) begin
        m_ph++;
        if (m_ph == TICK_DIV) begin
          m_ph = 0;
          term = m_up ? cnt_max : (DOWN_EN ? cnt_zero : 1'b0);
          if (term) begin m_st = 3; e_done = 1'b1; end
          else e_step = 1'b1;
        end
      end
    end
    // The filter sees the raw value two edges late; it flips after DEB samples all disagree.
    for (int k = 0; k < 3; k++) begin
      bit all_diff;
      for (int i = 0; i < HL - 1; i++) hist[k][i] = hist[k][i+1];
      hist[k][HL-1] = raw[k];
      all_diff = 1'b1;
      for (int i = 0; i < DEB; i++) if (hist[k][i] == m_lvl[k]) all_diff = 1'b0;
      pend[k] = 1'b0;
      if (all_diff) begin
        m_lvl[k] = !m_lvl[k];
        pend[k]  = (m_lvl[k] == 1'b0);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    chk("state", state, m_st);
    chk("run", run, (m_st == 1));
    chk("step", cnt_step, e_step);
    chk("clr", cnt_clr, e_clr);
    chk("done", done, e_done);
    chk("up", cnt_up, m_up);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic key_pulse(input int k, input int len);
    if (k == 0) key_clr_n = 1'b0;
    else if (k == 1) key_start_n = 1'b0;
    else key_dir_n = 1'b0;
    repeat (len) cycle();
    key_clr_n = 1'b1; key_start_n = 1'b1; key_dir_n = 1'b1;
  endtask

  task automatic run_count(input int n, output int nclr, output int ndone, output int nstep);
    nclr = 0; ndone = 0; nstep = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (cnt_clr) nclr++;
      if (done) ndone++;
      if (cnt_step) nstep++;
    end
  endtask

  initial begin
    int nc, nd, ns;
    model_reset();
    idle(3);
    chk("rst_state", state, 0);
    chk("rst_run", run, 0);
    chk("rst_up", cnt_up, 1);
    chk("rst_step", cnt_step, 0);

    // First start press; step cadence from entry to RUN.
    rst_n = 1'b1;
    key_start_n = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      cycle();
      if (c == 5) chk("run_e5", run, 0);
      if (c == 6) chk("run_e6", run, 1);
      if (c == 9) chk("step_e9", cnt_step, 0);
      if (c == 10 || c == 14) chk("step_e10_14", cnt_step, 1);
      if (c == 10) key_start_n = 1'b1;
    end
    idle(4);

    // Pause and resume.
    key_pulse(1, 4); idle(6);
    chk("pause", state, 2);
    run_count(8, nc, nd, ns);
    chk("pause_nostep", ns, 0);
    key_pulse(1, 4); idle(6);
    chk("resume", state, 1);

    // Short glitch ignored, DEB-long low accepted.
    key_pulse(1, 2); idle(8);
    chk("glitch2", state, 1);
    key_pulse(1, 3); idle(6);
    chk("glitch3", state, 2);

    // Same-cycle start and clear: clear wins.
    key_pulse(1, 4); idle(6);
    chk("rerun", state, 1);
    key_start_n = 1'b0; key_clr_n = 1'b0;
    idle(4);
    key_start_n = 1'b1; key_clr_n = 1'b1;
    run_count(10, nc, nd, ns);
    chk("simul_clr", nc, 1);
    chk("simul_state", state, 0);

    // Terminal reached: HOLD, then start clears and reruns.
    key_pulse(1, 4); idle(3);
    chk("run_hold_pre", state, 1);
    cnt_max = 1'b1;
    run_count(12, nc, nd, ns);
    cnt_max = 1'b0;
    chk("hold_done", nd, 1);
    chk("hold_nostep", ns, 0);
    chk("hold_state", state, 3);
    key_pulse(1, 4);
    run_count(6, nc, nd, ns);
    chk("hold_clr", nc, 1);
    chk("hold_rerun", state, 1);

    // Direction key.
    key_pulse(0, 4); idle(6);
    chk("clr_idle", state, 0);
    key_pulse(2, 4); idle(6);
`ifdef CNT_CTRL_DOWN_EN
    chk("dir_idle", cnt_up, 0);
    key_pulse(1, 4); idle(6);
    key_pulse(2, 4); idle(6);
    chk("dir_run", cnt_up, 0);
    chk("dir_run_state", state, 1);
    cnt_zero = 1'b1;
    run_count(12, nc, nd, ns);
    cnt_zero = 1'b0;
    chk("zero_done", nd, 1);
    chk("zero_hold", state, 3);
    key_pulse(0, 4); idle(6);
`else
    chk("dir_ignored", cnt_up, 1);
`endif

    // Asynchronous reset while running.
    key_pulse(1, 4); idle(4);
    chk("pre_rst_run", run, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_run", run, 0);
    chk("arst_step", cnt_step, 0);
    chk("arst_clr", cnt_clr, 0);
    chk("arst_done", done, 0);
    chk("arst_up", cnt_up, 1);
    idle(2);
    rst_n = 1'b1;
    run_count(6, nc, nd, ns);
    chk("post_rst_quiet", nc + ns, 0);

    // Random key bouncing and terminal inputs.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) key_start_n = ~key_start_n;
      if (key_clr_n) key_clr_n = ($urandom_range(0, 60) != 0);
      else key_clr_n = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) key_dir_n = ~key_dir_n;
      cnt_max  = ($urandom_range(0, 9) == 0);
      cnt_zero = ($urandom_range(0, 9) == 0);
      if (i == 1500) rst_n = 1'b0;
      if (i == 1502) rst_n = 1'b1;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
